// File: rtl/sram_byte_bridge.sv
// -----------------------------------------------------------------------------
// sram_byte_bridge
//   Bridges the 8-bit soc_65xx external RAM bus onto the 16-bit sram
//   controller. CPU byte reads pick one lane of an SRAM word; byte writes are
//   done as read-modify-write. A one-word read cache serves repeated accesses
//   to the same word without an SRAM cycle and supplies the merge word for
//   write hits. Hung SRAM cycles are aborted after TIMEOUT strobe cycles.
//
// Parameters
//   BANK      upper SRAM word-address bits [17:16]
//   TIMEOUT   strobe cycles before an SRAM access is aborted (0 = never)
//   CACHE_EN  1 enables the one-word read cache
//
// Ports
//   clk              system clock (sram domain)
//   reset_n          asynchronous active-low reset
//   cpu_addr         CPU byte address
//   cpu_do           CPU write data
//   cpu_read         CPU read request level
//   cpu_write        CPU write request level (wins over cpu_read)
//   cpu_di           registered read data to the CPU
//   cpu_rdy          CPU ready, low stalls the CPU
//   sram_address     SRAM word address {BANK, 1'b0, cpu_addr[15:1]}
//   sram_data_write  SRAM write word
//   sram_data_read   SRAM read word, valid while sram_ready is high
//   sram_read        SRAM read strobe level
//   sram_write       SRAM write strobe level
//   sram_ready       one-cycle completion pulse from the sram controller
//   err              sticky timeout flag, cleared only by reset
// -----------------------------------------------------------------------------
module sram_byte_bridge #(
   parameter logic [1:0]  BANK     = 2'b00,
   parameter int unsigned TIMEOUT  = 255,
   parameter bit          CACHE_EN = 1'b1
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [15:0] cpu_addr,
   input  logic [7:0]  cpu_do,
   input  logic        cpu_read,
   input  logic        cpu_write,
   output logic [7:0]  cpu_di,
   output logic        cpu_rdy,
   output logic [17:0] sram_address,
   output logic [15:0] sram_data_write,
   input  logic [15:0] sram_data_read,
   output logic        sram_read,
   output logic        sram_write,
   input  logic        sram_ready,
   output logic        err
);

   typedef enum logic [2:0] {IDLE, RD, RMW_RD, WR, DONE} state_t;

   // The counter holds the number of strobe cycles already spent; the access
   // is aborted on the edge that would bring it to TIMEOUT.
   localparam int unsigned      CW        = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [CW-1:0]    TOUT_LAST = CW'(TIMEOUT - 1);

   state_t         state, state_nxt;
   logic [CW-1:0]  tout_cnt, tout_cnt_nxt;
   logic           lane, lane_nxt;          // byte lane captured at IDLE exit
   logic [7:0]     wr_byte, wr_byte_nxt;    // CPU write byte captured at IDLE exit
   logic [7:0]     cpu_di_nxt;
   logic [17:0]    sram_address_nxt;
   logic [15:0]    sram_data_write_nxt;
   logic           sram_read_nxt, sram_write_nxt, err_nxt;

   logic           cache_valid;
   logic [14:0]    cache_tag;
   logic [15:0]    cache_data;
   logic           cache_load;
   logic [15:0]    cache_load_data;

   logic           hit, strobe_done, tout;

   function automatic logic [7:0] sel_byte(input logic [15:0] word, input logic hi);
      return hi ? word[15:8] : word[7:0];
   endfunction

   function automatic logic [15:0] merge_byte(input logic [15:0] word, input logic hi,
                                              input logic [7:0] b);
      return hi ? {b, word[7:0]} : {word[15:8], b};
   endfunction

   assign hit         = CACHE_EN && cache_valid && (cache_tag == cpu_addr[15:1]);
   // A ready pulse only counts while our own strobe is up.
   assign strobe_done = sram_ready && (sram_read || sram_write);
   assign tout        = (TIMEOUT != 0) && (tout_cnt == TOUT_LAST);

   // NOTE: every signal written here gets a default first, so no path leaves
   // one unassigned and no latch is inferred.
   always_comb begin
      state_nxt           = state;
      tout_cnt_nxt        = tout_cnt;
      lane_nxt            = lane;
      wr_byte_nxt         = wr_byte;
      cpu_di_nxt          = cpu_di;
      sram_address_nxt    = sram_address;
      sram_data_write_nxt = sram_data_write;
      sram_read_nxt       = sram_read;
      sram_write_nxt      = sram_write;
      err_nxt             = err;
      cache_load          = 1'b0;
      cache_load_data     = sram_data_write;
      cpu_rdy             = 1'b0;

      case (state)
         IDLE: begin
            cpu_rdy = ~cpu_write & ~(cpu_read & ~hit);
            if (cpu_write || (cpu_read && !hit)) begin
               sram_address_nxt = {BANK, 1'b0, cpu_addr[15:1]};
               lane_nxt         = cpu_addr[0];
               wr_byte_nxt      = cpu_do;
               tout_cnt_nxt     = '0;
            end
            if (cpu_write) begin
               if (hit) begin
                  sram_data_write_nxt = merge_byte(cache_data, cpu_addr[0], cpu_do);
                  sram_write_nxt      = 1'b1;
                  state_nxt           = WR;
               end else begin
                  sram_read_nxt = 1'b1;
                  state_nxt     = RMW_RD;
               end
            end else if (cpu_read) begin
               if (hit) begin
                  cpu_di_nxt = sel_byte(cache_data, cpu_addr[0]);
               end else begin
                  sram_read_nxt = 1'b1;
                  state_nxt     = RD;
               end
            end
         end

         RD, RMW_RD, WR: begin
            if (strobe_done) begin
               sram_read_nxt  = 1'b0;
               sram_write_nxt = 1'b0;
               state_nxt      = DONE;
               if (state == RD) begin
                  cpu_di_nxt      = sel_byte(sram_data_read, lane);
                  cache_load      = 1'b1;
                  cache_load_data = sram_data_read;
               end else if (state == RMW_RD) begin
                  sram_data_write_nxt = merge_byte(sram_data_read, lane, wr_byte);
                  sram_write_nxt      = 1'b1;
                  tout_cnt_nxt        = '0;
                  state_nxt           = WR;
               end else begin
                  cache_load = 1'b1;       // write-through with allocate
               end
            end else if (tout) begin
               sram_read_nxt  = 1'b0;
               sram_write_nxt = 1'b0;
               err_nxt        = 1'b1;
               cpu_di_nxt     = 8'hFF;
               state_nxt      = DONE;
            end else begin
               tout_cnt_nxt = tout_cnt + CW'(1);
            end
         end

         DONE: begin
            cpu_rdy   = 1'b1;
            state_nxt = IDLE;
         end

         default: state_nxt = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples its input from before the edge, independent of block order.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state           <= IDLE;
         tout_cnt        <= '0;
         lane            <= 1'b0;
         wr_byte         <= 8'h00;
         cpu_di          <= 8'h00;
         sram_address    <= '0;
         sram_data_write <= '0;
         sram_read       <= 1'b0;
         sram_write      <= 1'b0;
         err             <= 1'b0;
         cache_valid     <= 1'b0;
      end else begin
         state           <= state_nxt;
         tout_cnt        <= tout_cnt_nxt;
         lane            <= lane_nxt;
         wr_byte         <= wr_byte_nxt;
         cpu_di          <= cpu_di_nxt;
         sram_address    <= sram_address_nxt;
         sram_data_write <= sram_data_write_nxt;
         sram_read       <= sram_read_nxt;
         sram_write      <= sram_write_nxt;
         err             <= err_nxt;
         if (cache_load) cache_valid <= 1'b1;
      end
   end

   // NOTE: cache tag/data are storage qualified by cache_valid, so they carry
   // no reset; only the valid bit must come up cleared.
   always_ff @(posedge clk) begin
      if (cache_load) begin
         cache_tag  <= sram_address[14:0];
         cache_data <= cache_load_data;
      end
   end

endmodule

// File: tb/tb_sram_byte_bridge.sv
// -----------------------------------------------------------------------------
// tb_sram_byte_bridge
//   Directed bench for sram_byte_bridge with a small behavioural sram
//   controller (fixed latency, optional hang) and hand-computed expectations.
// -----------------------------------------------------------------------------
module tb_sram_byte_bridge;

   localparam int LAT = 2;       // model: strobe cycles until sram_ready

   logic        clk;
   logic        reset_n;
   logic [15:0] cpu_addr;
   logic [7:0]  cpu_do;
   logic        cpu_read;
   logic        cpu_write;
   logic [7:0]  cpu_di;
   logic        cpu_rdy;
   logic [17:0] sram_address;
   logic [15:0] sram_data_write;
   logic [15:0] sram_data_read;
   logic        sram_read;
   logic        sram_write;
   logic        sram_ready;
   logic        err;

   int n_checks = 0;
   int n_fail   = 0;

   // sram model state and observation counters
   logic [15:0] mem [0:1023];
   bit          hang;
   int          rd_starts, wr_starts, rd_cycles, both_hi;
   logic [17:0] last_raddr, last_waddr;
   logic [15:0] last_wdata;

   sram_byte_bridge #(.BANK(2'b00), .TIMEOUT(8), .CACHE_EN(1'b1)) dut (
      .clk             (clk),
      .reset_n         (reset_n),
      .cpu_addr        (cpu_addr),
      .cpu_do          (cpu_do),
      .cpu_read        (cpu_read),
      .cpu_write       (cpu_write),
      .cpu_di          (cpu_di),
      .cpu_rdy         (cpu_rdy),
      .sram_address    (sram_address),
      .sram_data_write (sram_data_write),
      .sram_data_read  (sram_data_read),
      .sram_read       (sram_read),
      .sram_write      (sram_write),
      .sram_ready      (sram_ready)  ,
      .err             (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Behavioural sram controller, evaluated on the falling edge.
   initial begin : sram_model
      logic [1:0] kind, prev_kind;
      int         wait_cnt;
      bit         served;
      prev_kind = 2'b00; wait_cnt = 0; served = 1'b0;
      sram_ready = 1'b0; sram_data_read = 16'hDEAD;
      forever begin
         @(negedge clk);
         sram_ready     = 1'b0;
         sram_data_read = 16'hDEAD;
         kind           = {sram_write, sram_read};
         if (!reset_n) begin
            prev_kind = 2'b00;
         end else begin
            if (kind == 2'b11) both_hi++;
            if (kind != prev_kind) begin
               wait_cnt = 0;
               served   = 1'b0;
               if (kind[0]) begin rd_starts++; last_raddr = sram_address; end
               if (kind[1]) wr_starts++;
            end
            prev_kind = kind;
            if (kind[0]) rd_cycles++;
            if (kind != 2'b00 && !served && !hang) begin
               wait_cnt++;
               if (wait_cnt >= LAT) begin
                  sram_ready = 1'b1;
                  served     = 1'b1;
                  if (kind[1]) begin
                     mem[sram_address[9:0]] = sram_data_write;
                     last_waddr = sram_address;
                     last_wdata = sram_data_write;
                  end else begin
                     sram_data_read = mem[sram_address[9:0]];
                  end
               end
            end
         end
      end
   end

   // One CPU access: request held until cpu_rdy is seen, completing on the
   // following rising edge. stalls counts cycles with cpu_rdy low.
   task automatic access(input logic wr, input logic [15:0] a, input logic [7:0] d,
                         output int stalls);
      bit ok;
      @(negedge clk);
      cpu_addr  = a;
      cpu_do    = d;
      cpu_read  = ~wr;
      cpu_write = wr;
      stalls    = 0;
      ok        = 1'b0;
      for (int i = 0; i < 100; i++) begin
         #1;
         if (cpu_rdy) begin ok = 1'b1; break; end
         stalls++;
         @(negedge clk);
      end
      check("access_completes", 32'(ok), 32'd1);
      @(posedge clk);
      #1;
      cpu_read  = 1'b0;
      cpu_write = 1'b0;
   endtask

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog expired");
   end

   initial begin : stim
      int st, r0, w0, c0;
      for (int i = 0; i < 1024; i++) mem[i] = 16'h0000;
      mem[10'h100] = 16'hBEEF;
      mem[10'h180] = 16'h1234;
      mem[10'h280] = 16'hCAFE;
      hang = 1'b0;
      cpu_addr = '0; cpu_do = '0; cpu_read = 1'b0; cpu_write = 1'b0;
      reset_n = 1'b1;
      #2 reset_n = 1'b0;
      #10;
      check("rst_cpu_di",   32'(cpu_di),          32'h00);
      check("rst_sram_rd",  32'(sram_read),       32'd0);
      check("rst_sram_wr",  32'(sram_write),      32'd0);
      check("rst_addr",     32'(sram_address),    32'h0);
      check("rst_wdata",    32'(sram_data_write), 32'h0);
      check("rst_err",      32'(err),             32'd0);
      check("rst_cpu_rdy",  32'(cpu_rdy),         32'd1);
      @(negedge clk); reset_n = 1'b1;
      repeat (2) @(negedge clk);

      // 1: read miss of 0x0201 -> word 0x00100, high lane
      r0 = rd_starts;
      access(1'b0, 16'h0201, 8'h00, st);
      check("t1_rd_strobe", 32'(rd_starts - r0), 32'd1);
      check("t1_addr",      32'(last_raddr),     32'h00100);
      check("t1_stall",     32'(st),             32'(LAT + 1));
      check("t1_data",      32'(cpu_di),         32'hBE);

      // 2: read hit of 0x0200 -> low lane from cache
      r0 = rd_starts;
      access(1'b0, 16'h0200, 8'h00, st);
      check("t2_no_strobe", 32'(rd_starts - r0), 32'd0);
      check("t2_stall",     32'(st),             32'd0);
      check("t2_data",      32'(cpu_di),         32'hEF);

      // 3: write miss 0x55 to 0x0301 -> RMW of 0x1234
      r0 = rd_starts; w0 = wr_starts;
      access(1'b1, 16'h0301, 8'h55, st);
      check("t3_rd_strobe", 32'(rd_starts - r0), 32'd1);
      check("t3_wr_strobe", 32'(wr_starts - w0), 32'd1);
      check("t3_waddr",     32'(last_waddr),     32'h00180);
      check("t3_wdata",     32'(last_wdata),     32'h5534);

      // 4: write hit 0xAA to 0x0300, then read it back from cache
      r0 = rd_starts; w0 = wr_starts;
      access(1'b1, 16'h0300, 8'hAA, st);
      check("t4_no_rd",     32'(rd_starts - r0), 32'd0);
      check("t4_wr_strobe", 32'(wr_starts - w0), 32'd1);
      check("t4_wdata",     32'(last_wdata),     32'h55AA);
      r0 = rd_starts; w0 = wr_starts;
      access(1'b0, 16'h0300, 8'h00, st);
      check("t4_hit_data",  32'(cpu_di),         32'hAA);
      check("t4_hit_stall", 32'(st),             32'd0);
      check("t4_hit_nostb", 32'((rd_starts - r0) + (wr_starts - w0)), 32'd0);

      // 5: hung sram, read miss 0x0400 -> abort after 8 strobe cycles
      hang = 1'b1;
      c0 = rd_cycles;
      access(1'b0, 16'h0400, 8'h00, st);
      check("t5_strobe_cyc", 32'(rd_cycles - c0), 32'd8);
      check("t5_stall",      32'(st),             32'd9);
      check("t5_data",       32'(cpu_di),         32'hFF);
      check("t5_err",        32'(err),            32'd1);
      check("t5_rd_low",     32'(sram_read),      32'd0);
      // write miss aborted in the read phase must not write
      w0 = wr_starts;
      access(1'b1, 16'h0501, 8'h77, st);
      check("t5_no_write",   32'(wr_starts - w0), 32'd0);
      check("t5_mem_kept",   32'(mem[10'h280]),   32'hCAFE);
      check("t5_err_sticky", 32'(err),            32'd1);
      hang = 1'b0;
      r0 = rd_starts;
      access(1'b0, 16'h0300, 8'h00, st);
      check("t5_cache_kept", 32'(cpu_di),         32'hAA);
      check("t5_cache_nord", 32'(rd_starts - r0), 32'd0);

      // 6: reset while a write miss sits in RMW_RD
      hang = 1'b1;
      @(negedge clk);
      cpu_addr = 16'h0501; cpu_do = 8'h77; cpu_write = 1'b1;
      @(negedge clk);
      check("t6_in_rmw",    32'(sram_read),       32'd1);
      #2 reset_n = 1'b0;
      #1;
      check("t6_rst_rd",    32'(sram_read),       32'd0);
      check("t6_rst_wr",    32'(sram_write),      32'd0);
      check("t6_rst_addr",  32'(sram_address),    32'h0);
      check("t6_rst_wdata", 32'(sram_data_write), 32'h0);
      check("t6_rst_di",    32'(cpu_di),          32'h00);
      check("t6_rst_err",   32'(err),             32'd0);
      cpu_write = 1'b0;
      #1;
      check("t6_rst_rdy",   32'(cpu_rdy),         32'd1);
      @(negedge clk); reset_n = 1'b1; hang = 1'b0;
      r0 = rd_starts; w0 = wr_starts;
      access(1'b0, 16'h0300, 8'h00, st);
      check("t6_inval_rd",   32'(rd_starts - r0), 32'd1);
      check("t6_inval_data", 32'(cpu_di),         32'hAA);
      r0 = rd_starts;
      access(1'b0, 16'h0200, 8'h00, st);
      check("t6_rd_0200",    32'(rd_starts - r0), 32'd1);
      check("t6_data_0200",  32'(cpu_di),         32'hEF);
      check("t6_no_write",   32'(wr_starts - w0), 32'd0);
      check("t6_mem_kept",   32'(mem[10'h280]),   32'hCAFE);

      check("one_strobe",    32'(both_hi),        32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
